// File: rtl/synth_pkg.sv
// Shared constants and types for the synth voice control core.
// Envelope state encodings, ADSR bank indices and pitch field widths.
package synth_pkg;

    localparam int NOTE_W      = 4;
    localparam int OCT_W       = 3;
    localparam int SEL_W       = 3;
    localparam int NUM_PARAMS  = 5;
    localparam int NUM_STROBES = 6;

    localparam logic [SEL_W-1:0] IDX_VOL = 3'd0;
    localparam logic [SEL_W-1:0] IDX_ATK = 3'd1;
    localparam logic [SEL_W-1:0] IDX_DEC = 3'd2;
    localparam logic [SEL_W-1:0] IDX_SUS = 3'd3;
    localparam logic [SEL_W-1:0] IDX_REL = 3'd4;

    // Bit positions of each strobe inside the synchroniser vector
    localparam int STB_NOTE   = 0;
    localparam int STB_KEY_UP = 1;
    localparam int STB_OCT_UP = 2;
    localparam int STB_OCT_DN = 3;
    localparam int STB_PAR_UP = 4;
    localparam int STB_PAR_DN = 5;

    typedef enum logic [2:0] {
        ENV_IDLE    = 3'd0,
        ENV_ATTACK  = 3'd1,
        ENV_DECAY   = 3'd2,
        ENV_SUSTAIN = 3'd3,
        ENV_RELEASE = 3'd4
    } env_state_t;

endpackage

// File: rtl/adsr_envelope.sv
// Single-voice ADSR envelope: tick divider, state machine and clamped amplitude arithmetic.
// Amplitude moves only on ticks; retrigger and release events act immediately on the state.
module adsr_envelope
    import synth_pkg::*;
#(
    parameter int PARAM_W  = 4,
    parameter int AMP_W    = 8,
    parameter int TICK_DIV = 50000
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic [PARAM_W-1:0] vol,
    input  logic [PARAM_W-1:0] atk,
    input  logic [PARAM_W-1:0] dec,
    input  logic [PARAM_W-1:0] sus,
    input  logic [PARAM_W-1:0] rel,
    input  logic               retrigger,
    input  logic               key_release,
    output logic [AMP_W-1:0]   amp,
    output env_state_t         state
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam int SUM_W = AMP_W + 1;
    localparam logic [SUM_W-1:0] FULL_SCALE = SUM_W'(2 ** PARAM_W);

    logic [CNT_W-1:0] tick_cnt;
    logic             tick;

    assign tick = (tick_cnt == CNT_LAST);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset)
            tick_cnt <= '0;
        else if (tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + 1'b1;
    end

    // One spare bit of headroom so overshoot and underflow are visible before clamping
    logic [SUM_W-1:0] amp_ext, peak, sus_full, sus_lvl;
    logic [SUM_W-1:0] step_a, step_d, step_r;
    logic [SUM_W-1:0] sum_atk, diff_dec, diff_rel;
    logic             dec_done, rel_done;

    assign amp_ext  = {1'b0, amp};
    assign peak     = {1'b0, vol, vol};
    assign sus_full = {1'b0, sus, sus};
    assign sus_lvl  = (sus_full < peak) ? sus_full : peak;
    assign step_a   = FULL_SCALE - SUM_W'(atk);
    assign step_d   = FULL_SCALE - SUM_W'(dec);
    assign step_r   = FULL_SCALE - SUM_W'(rel);
    assign sum_atk  = amp_ext + step_a;
    assign diff_dec = amp_ext - step_d;
    assign diff_rel = amp_ext - step_r;
    assign dec_done = diff_dec[SUM_W-1] || (diff_dec <= sus_lvl);
    assign rel_done = diff_rel[SUM_W-1] || (diff_rel == '0);

    env_state_t       state_next;
    logic [AMP_W-1:0] amp_next;

    always_comb begin
        state_next = state;
        amp_next   = amp;
        if (retrigger) begin
            state_next = ENV_ATTACK;
        end else if (key_release && (state == ENV_ATTACK || state == ENV_DECAY ||
                                     state == ENV_SUSTAIN)) begin
            state_next = ENV_RELEASE;
        end else if (tick) begin
            case (state)
                ENV_IDLE: amp_next = '0;
                ENV_ATTACK: begin
                    if (sum_atk >= peak) begin
                        amp_next   = peak[AMP_W-1:0];
                        state_next = ENV_DECAY;
                    end else begin
                        amp_next = sum_atk[AMP_W-1:0];
                    end
                end
                ENV_DECAY: begin
                    if (dec_done) begin
                        amp_next   = sus_lvl[AMP_W-1:0];
                        state_next = ENV_SUSTAIN;
                    end else begin
                        amp_next = diff_dec[AMP_W-1:0];
                    end
                end
                ENV_SUSTAIN: amp_next = sus_lvl[AMP_W-1:0];
                ENV_RELEASE: begin
                    if (rel_done) begin
                        amp_next   = '0;
                        state_next = ENV_IDLE;
                    end else begin
                        amp_next = diff_rel[AMP_W-1:0];
                    end
                end
                default: begin
                    amp_next   = '0;
                    state_next = ENV_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state <= ENV_IDLE;
            amp   <= '0;
        end else begin
            state <= state_next;
            amp   <= amp_next;
        end
    end

endmodule

// File: rtl/synth_voice_ctrl.sv
// Voice control core: synchronises decoder strobes, holds octave and ADSR bank,
// and drives the envelope that sets pitch and amplitude for the oscillator.
module synth_voice_ctrl
    import synth_pkg::*;
#(
    parameter int PARAM_W       = 4,
    parameter int AMP_W         = 8,
    parameter int OCT_MAX       = 7,
    parameter int OCT_DEFAULT   = 4,
    parameter int PARAM_DEFAULT = 8,
    parameter int TICK_DIV      = 50000
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic [NOTE_W-1:0]  note,
    input  logic               note_in,
    input  logic               key_up,
    input  logic               octave_plus_plus,
    input  logic               octave_minus_minus,
    input  logic [SEL_W-1:0]   ADSR_selector,
    input  logic               ADSR_plus_plus,
    input  logic               ADSR_minus_minus,
    output logic [NOTE_W-1:0]  play_note,
    output logic [OCT_W-1:0]   play_octave,
    output logic [AMP_W-1:0]   amplitude,
    output logic               voice_active,
    output logic [2:0]         env_state,
    output logic [PARAM_W-1:0] sel_value
);

    localparam logic [PARAM_W-1:0] PARAM_MAX = '1;
    localparam logic [PARAM_W-1:0] PARAM_RST = PARAM_W'(PARAM_DEFAULT);
    localparam logic [OCT_W-1:0]   OCT_TOP   = OCT_W'(OCT_MAX);
    localparam logic [OCT_W-1:0]   OCT_RST   = OCT_W'(OCT_DEFAULT);

    logic [NUM_STROBES-1:0] strobe_raw, strobe_s1, strobe_s2, strobe_prev, strobe_edge;
    logic [NOTE_W-1:0]      note_s1, note_s2;
    logic [SEL_W-1:0]       sel_s1, sel_s2;

    assign strobe_raw = {ADSR_minus_minus, ADSR_plus_plus, octave_minus_minus,
                         octave_plus_plus, key_up, note_in};

    // Data buses share the strobes' two-flop path so they line up with the edge pulse
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            strobe_s1   <= '0;
            strobe_s2   <= '0;
            strobe_prev <= '0;
            strobe_edge <= '0;
            note_s1     <= '0;
            note_s2     <= '0;
            sel_s1      <= '0;
            sel_s2      <= '0;
        end else begin
            strobe_s1   <= strobe_raw;
            strobe_s2   <= strobe_s1;
            strobe_prev <= strobe_s2;
            strobe_edge <= strobe_s2 & ~strobe_prev;
            note_s1     <= note;
            note_s2     <= note_s1;
            sel_s1      <= ADSR_selector;
            sel_s2      <= sel_s1;
        end
    end

    logic note_edge, key_up_edge, oct_up_edge, oct_dn_edge, par_up_edge, par_dn_edge;
    logic sel_valid;

    assign note_edge   = strobe_edge[STB_NOTE];
    assign key_up_edge = strobe_edge[STB_KEY_UP];
    assign oct_up_edge = strobe_edge[STB_OCT_UP];
    assign oct_dn_edge = strobe_edge[STB_OCT_DN];
    assign par_up_edge = strobe_edge[STB_PAR_UP];
    assign par_dn_edge = strobe_edge[STB_PAR_DN];
    assign sel_valid   = (sel_s2 <= IDX_REL);

    logic [OCT_W-1:0] octave;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset)
            octave <= OCT_RST;
        else if (oct_up_edge && !oct_dn_edge && octave != OCT_TOP)
            octave <= octave + 1'b1;
        else if (oct_dn_edge && !oct_up_edge && octave != '0)
            octave <= octave - 1'b1;
    end

    logic [PARAM_W-1:0] params [NUM_PARAMS];

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_PARAMS; i++)
                params[i] <= PARAM_RST;
        end else if (sel_valid && (par_up_edge ^ par_dn_edge)) begin
            if (par_up_edge && params[sel_s2] != PARAM_MAX)
                params[sel_s2] <= params[sel_s2] + 1'b1;
            else if (par_dn_edge && params[sel_s2] != '0)
                params[sel_s2] <= params[sel_s2] - 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset)
            sel_value <= '0;
        else
            sel_value <= sel_valid ? params[sel_s2] : '0;
    end

    // Octave edits reach the oscillator only when the next note is struck
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            play_note   <= '0;
            play_octave <= OCT_RST;
        end else if (note_edge) begin
            play_note   <= note_s2;
            play_octave <= octave;
        end
    end

    env_state_t env_state_q;

    adsr_envelope #(
        .PARAM_W  (PARAM_W),
        .AMP_W    (AMP_W),
        .TICK_DIV (TICK_DIV)
    ) u_envelope (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .vol         (params[IDX_VOL]),
        .atk         (params[IDX_ATK]),
        .dec         (params[IDX_DEC]),
        .sus         (params[IDX_SUS]),
        .rel         (params[IDX_REL]),
        .retrigger   (note_edge),
        .key_release (key_up_edge),
        .amp         (amplitude),
        .state       (env_state_q)
    );

    assign env_state    = env_state_q;
    assign voice_active = (env_state_q != ENV_IDLE);

endmodule

// File: tb/tb_synth_voice_ctrl.sv
// Randomised scoreboard bench for synth_voice_ctrl with a behavioural envelope model.
module tb_synth_voice_ctrl;

    localparam int TICK_DIV = 4;

    localparam logic [5:0] M_NOTE   = 6'b000001;
    localparam logic [5:0] M_KEY_UP = 6'b000010;
    localparam logic [5:0] M_OCT_UP = 6'b000100;
    localparam logic [5:0] M_OCT_DN = 6'b001000;

    logic       CLOCK_50 = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] note = '0;
    logic       note_in = 1'b0, key_up = 1'b0;
    logic       octave_plus_plus = 1'b0, octave_minus_minus = 1'b0;
    logic [2:0] ADSR_selector = '0;
    logic       ADSR_plus_plus = 1'b0, ADSR_minus_minus = 1'b0;
    logic [3:0] play_note;
    logic [2:0] play_octave;
    logic [7:0] amplitude;
    logic       voice_active;
    logic [2:0] env_state;
    logic [3:0] sel_value;

    synth_voice_ctrl #(.TICK_DIV(TICK_DIV)) dut (
        .CLOCK_50           (CLOCK_50),
        .reset              (reset),
        .note               (note),
        .note_in            (note_in),
        .key_up             (key_up),
        .octave_plus_plus   (octave_plus_plus),
        .octave_minus_minus (octave_minus_minus),
        .ADSR_selector      (ADSR_selector),
        .ADSR_plus_plus     (ADSR_plus_plus),
        .ADSR_minus_minus   (ADSR_minus_minus),
        .play_note          (play_note),
        .play_octave        (play_octave),
        .amplitude          (amplitude),
        .voice_active       (voice_active),
        .env_state          (env_state),
        .sel_value          (sel_value)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    typedef struct packed {
        logic [2:0] st;
        logic [7:0] amp;
    } env_txn_t;

    env_txn_t   env_q[$];
    logic [6:0] pitch_q[$];
    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: octave, parameter bank and the amplitude the voice will settle at
    int m_oct = 4;
    int m_par[5] = '{8, 8, 8, 8, 8};
    int m_amp = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic int peakLvl();
        return m_par[0] * 17;
    endfunction

    function automatic int susLvl();
        int s;
        s = m_par[3] * 17;
        return (s < peakLvl()) ? s : peakLvl();
    endfunction

    task automatic pushEnv(input int st, input int a);
        env_txn_t t;
        t.st  = 3'(st);
        t.amp = 8'(a);
        env_q.push_back(t);
    endtask

    // Every envelope tick from a note strike up to the sustain plateau
    task automatic genNoteOn(input int from);
        int a;
        a = from;
        pushEnv(1, a);
        while (1) begin
            a += 16 - m_par[1];
            if (a >= peakLvl()) begin
                a = peakLvl();
                pushEnv(2, a);
                break;
            end
            pushEnv(1, a);
        end
        while (1) begin
            a -= 16 - m_par[2];
            if (a <= susLvl()) begin
                a = susLvl();
                pushEnv(3, a);
                break;
            end
            pushEnv(2, a);
        end
        m_amp = a;
    endtask

    task automatic genRelease(input int stop_at);
        int a;
        a = m_amp;
        pushEnv(4, a);
        while (1) begin
            a -= 16 - m_par[4];
            if (a <= 0) begin
                a = 0;
                pushEnv(0, 0);
                break;
            end
            pushEnv(4, a);
            if (a == stop_at) break;
        end
        m_amp = a;
    endtask

    // Monitor: every change of (state, amplitude) is one transaction
    env_txn_t prev_obs = '0;
    always @(negedge CLOCK_50) begin
        env_txn_t   cur, exp_t;
        logic [6:0] exp_p;
        cur = {env_state, amplitude};
        if (reset) begin
            prev_obs = '0;
        end else if (cur != prev_obs) begin
            if (env_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL env_unexpected: got state %0d amp %0d, expected no change",
                         cur.st, cur.amp);
            end else begin
                exp_t = env_q.pop_front();
                checkOutput("env_state", int'(cur.st), int'(exp_t.st));
                checkOutput("amplitude", int'(cur.amp), int'(exp_t.amp));
            end
            checkOutput("voice_active", int'(voice_active), int'(cur.st != 3'd0));
            if (cur.st == 3'd1 && prev_obs.st != 3'd1) begin
                if (pitch_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("[TB] FAIL pitch_unexpected: got note %0d octave %0d, expected none",
                             play_note, play_octave);
                end else begin
                    exp_p = pitch_q.pop_front();
                    checkOutput("pitch", int'({play_note, play_octave}), int'(exp_p));
                end
            end
            prev_obs = cur;
        end
    end

    // Pulse the strobes in mask; caller is aligned just after a falling edge
    task automatic applyStimulus(input logic [5:0] mask);
        note_in            = mask[0];
        key_up             = mask[1];
        octave_plus_plus   = mask[2];
        octave_minus_minus = mask[3];
        ADSR_plus_plus     = mask[4];
        ADSR_minus_minus   = mask[5];
        repeat (2) @(negedge CLOCK_50);
        #1;
        {ADSR_minus_minus, ADSR_plus_plus, octave_minus_minus,
         octave_plus_plus, key_up, note_in} = '0;
        repeat (4) @(negedge CLOCK_50);
        #1;
    endtask

    task automatic waitDrain(input string name, input int budget);
        int n;
        n = 0;
        while (env_q.size() > 0 && n < budget) begin
            @(negedge CLOCK_50);
            #1;
            n++;
        end
        checkOutput(name, env_q.size(), 0);
        env_q.delete();
    endtask

    task automatic octPulse(input logic up, input logic dn);
        applyStimulus({2'b00, dn, up, 2'b00});
        if (up && !dn && m_oct < 7) m_oct++;
        else if (dn && !up && m_oct > 0) m_oct--;
    endtask

    task automatic paramPulse(input int sel, input logic up, input logic dn);
        ADSR_selector = 3'(sel);
        applyStimulus({dn, up, 4'b0000});
        if (sel < 5 && (up ^ dn)) begin
            if (up && m_par[sel] < 15) m_par[sel]++;
            else if (dn && m_par[sel] > 0) m_par[sel]--;
        end
    endtask

    task automatic checkSel(input int sel);
        ADSR_selector = 3'(sel);
        repeat (5) @(negedge CLOCK_50);
        #1;
        checkOutput($sformatf("sel_value[%0d]", sel), int'(sel_value),
                    (sel < 5) ? m_par[sel] : 0);
    endtask

    task automatic playNote(input int n, input logic [5:0] mask);
        note = 4'(n);
        pitch_q.push_back({4'(n), 3'(m_oct)});
        genNoteOn(m_amp);
        applyStimulus(mask);
        waitDrain("drain_attack_decay", 4000);
        genRelease(-1);
        applyStimulus(M_KEY_UP);
        waitDrain("drain_release", 4000);
    endtask

    task automatic doReset();
        reset = 1'b1;
        env_q.delete();
        pitch_q.delete();
        m_oct = 4;
        m_amp = 0;
        foreach (m_par[i]) m_par[i] = 8;
        repeat (2) @(negedge CLOCK_50);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #1_800_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        tests_failed++;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int start_sz, n;
        #2 reset = 1'b1;
        #3;
        checkOutput("rst_amplitude", int'(amplitude), 0);
        checkOutput("rst_env_state", int'(env_state), 0);
        checkOutput("rst_voice_active", int'(voice_active), 0);
        checkOutput("rst_play_octave", int'(play_octave), 4);
        checkOutput("rst_play_note", int'(play_note), 0);
        checkOutput("rst_sel_value", int'(sel_value), 0);
        @(negedge CLOCK_50);
        #1 reset = 1'b0;

        // Octave saturation in both directions and the simultaneous-edge hold
        repeat (3) octPulse(1'b1, 1'b0);
        playNote($urandom_range(0, 11), M_NOTE);
        repeat (8) octPulse(1'b0, 1'b1);
        playNote($urandom_range(0, 11), M_NOTE);
        octPulse(1'b1, 1'b0);
        octPulse(1'b1, 1'b1);
        playNote($urandom_range(0, 11), M_NOTE);

        // Parameter saturation and invalid selector
        repeat (7) paramPulse(0, 1'b1, 1'b0);
        checkSel(0);
        paramPulse(0, 1'b1, 1'b0);
        checkSel(0);
        paramPulse(6, 1'b1, 1'b0);
        checkSel(6);
        checkSel(0);
        checkSel(1);

        // Default envelope, release, then key_up while idle
        doReset();
        playNote(9, M_NOTE);
        applyStimulus(M_KEY_UP);
        repeat (8) @(negedge CLOCK_50);
        #1;
        checkOutput("idle_key_up_state", int'(env_state), 0);

        // Retrigger mid-release at amplitude 64
        note = 4'd5;
        pitch_q.push_back({4'd5, 3'(m_oct)});
        genNoteOn(m_amp);
        applyStimulus(M_NOTE);
        waitDrain("drain_retrig_attack", 4000);
        genRelease(64);
        applyStimulus(M_KEY_UP);
        waitDrain("drain_to_64", 4000);
        playNote(2, M_NOTE);

        // Note and key_up together: note wins
        playNote($urandom_range(0, 11), M_NOTE | M_KEY_UP);

        // Randomised octave/parameter edits followed by a full note
        repeat (5) begin
            repeat ($urandom_range(0, 4)) octPulse(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(2, 12)) begin
                n = $urandom_range(0, 2);
                paramPulse($urandom_range(0, 7), n != 1, n != 0);
            end
            checkSel($urandom_range(0, 7));
            playNote($urandom_range(0, 11), M_NOTE);
        end

        // Reset in the middle of an attack ramp
        octPulse(1'b1, 1'b0);
        paramPulse(1, 1'b1, 1'b0);
        note = 4'd11;
        pitch_q.push_back({4'd11, 3'(m_oct)});
        genNoteOn(m_amp);
        start_sz = env_q.size();
        applyStimulus(M_NOTE);
        n = 0;
        while (env_q.size() > start_sz - 3 && n < 200) begin
            @(negedge CLOCK_50);
            #1;
            n++;
        end
        checkOutput("mid_attack_state", int'(env_state), 1);
        #3 reset = 1'b1;
        #1;
        checkOutput("midrst_amplitude", int'(amplitude), 0);
        checkOutput("midrst_env_state", int'(env_state), 0);
        checkOutput("midrst_voice_active", int'(voice_active), 0);
        checkOutput("midrst_play_octave", int'(play_octave), 4);
        checkOutput("midrst_sel_value", int'(sel_value), 0);
        @(negedge CLOCK_50);
        #1;
        doReset();
        for (int i = 0; i < 5; i++) checkSel(i);
        playNote($urandom_range(0, 11), M_NOTE);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
